// File: rtl/spi_xfer_ctrl.sv
// SPI master frame controller: pops TX words, shifts one frame per word
// on sck/mosi/miso and pushes the received word into the RX FIFO.
module spi_xfer_ctrl #(
  parameter int DW    = 8,
  parameter int DIV_W = 8
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             cr_en,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic [DIV_W-1:0] br_div,
  input  logic             tfifo_empty,
  input  logic [DW-1:0]    tfifo_rdata,
  output logic             tfifo_ren,
  input  logic             rfifo_full,
  output logic             rfifo_wen,
  output logic [DW-1:0]    rfifo_wdata,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             ss_n,
  output logic             busy,
  output logic             done,
  input  logic             ovr_clr,
  output logic             ovr_err
);

  localparam int EW = $clog2(2 * DW);
  localparam logic [EW-1:0] LAST = EW'(2 * DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [DW-1:0]    tx_q, tx_d;
  logic [DW-1:0]    rx_q, rx_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             lsb_q, lsb_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;

  logic start, tick, fin, drv, smp;

  function automatic logic head_bit(
    input logic [DW-1:0] d,
    input logic          lsb
  );
    return lsb ? d[0] : d[DW-1];
  endfunction

  function automatic logic [DW-1:0] adv(
    input logic [DW-1:0] d,
    input logic          lsb
  );
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  // Pop is gated by reset so no strobe leaks out while held in reset.
  assign start = preset_n & (state_q == IDLE)
               & cr_en & ~tfifo_empty;
  assign tick  = (cnt_q == div_q);
  assign fin   = (state_q == HOLD) & tick;
  assign drv   = (state_q == SHIFT) & tick
               & (cpha_q ? ~edge_q[0]
                         : (edge_q[0] & (edge_q != LAST)));
  assign smp   = (state_q == SHIFT) & tick
               & (cpha_q ? edge_q[0] : ~edge_q[0]);

  assign tfifo_ren   = start;
  assign done        = fin;
  assign rfifo_wen   = fin & ~rfifo_full;
  assign rfifo_wdata = rx_q;
  assign sck         = sck_q;
  assign mosi        = mosi_q;
  assign ss_n        = ss_n_q;
  assign busy        = busy_q;
  assign ovr_err     = ovr_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = tick ? '0 : cnt_q + DIV_W'(1);
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    busy_d  = busy_q;
    // A set in the same cycle as a clear wins.
    ovr_d   = (ovr_q & ~ovr_clr) | (fin & rfifo_full);

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        edge_d = '0;
        sck_d  = cpol;
        mosi_d = 1'b0;
        ss_n_d = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d = SETUP;
          div_d   = br_div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          if (cpha) begin
            tx_d = tfifo_rdata;
          end else begin
            mosi_d = head_bit(tfifo_rdata, lsb_first);
            tx_d   = adv(tfifo_rdata, lsb_first);
          end
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + EW'(1);
          if (drv) begin
            mosi_d = head_bit(tx_q, lsb_q);
            tx_d   = adv(tx_q, lsb_q);
          end
          if (smp) begin
            rx_d = lsb_q ? {miso, rx_q[DW-1:1]}
                         : {rx_q[DW-2:0], miso};
          end
          if (edge_q == LAST) begin
            state_d = HOLD;
            edge_d  = '0;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = IDLE;
          sck_d   = cpol;
          mosi_d  = 1'b0;
          ss_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ss_n_q  <= ss_n_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule
